// File: rtl/cpc_bus_initiator_if.sv
// Command/response and expansion-bus signal bundle for the CPC bus initiator.
// The master modport is the initiator's view; the slave modport is the
// view of whatever drives commands and models the expansion card.
interface cpc_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        upper_en;
    logic        lower_en;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_romdis;
    logic [15:0] A;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic [7:0]  D_IN;
    logic        MREQ_B;
    logic        IOREQ_B;
    logic        RD_B;
    logic        WR_B;
    logic        ROMEN_B;
    logic        READY;
    logic        ROMDIS;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, upper_en, lower_en,
        input  D_IN, READY, ROMDIS,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_romdis,
        output A, D_OUT, D_OE, MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, upper_en, lower_en,
        output D_IN, READY, ROMDIS,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_romdis,
        input  A, D_OUT, D_OE, MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B
    );
endinterface

// File: rtl/cpc_bus_initiator.sv
// Z80-style CPC expansion-bus master. Runs T1/T2/TW/T3 sequences for IO
// write, memory read (with ROMEN_B qualification) and memory write, and
// returns read data plus the ROMDIS level seen at the end of T3.
// All bus strobes are registered: next-state logic decides the value each
// strobe takes in the state being entered.
module cpc_bus_initiator #(
    parameter int unsigned T_DIV            = 1,
    parameter logic [1:0]  ROMEN_UPPER_BASE = 2'b11
) (
    input logic                 CLK,
    input logic                 RESET,
    cpc_bus_initiator_if.master bus
);
    localparam logic [1:0] OP_IOWR = 2'b00;
    localparam logic [1:0] OP_MRD  = 2'b01;
    localparam logic [1:0] OP_MWR  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;
    localparam logic [3:0] TICK_LAST = 4'(T_DIV - 32'd1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4
    } state_t;

    // ROMEN_B qualifies only the upper (C000-FFFF) and lower (0000-3FFF) ROM windows.
    function automatic logic romen_hit(input logic [15:0] addr, input logic up_en, input logic lo_en);
        return ((addr[15:14] == ROMEN_UPPER_BASE) && up_en) || ((addr[15:14] == 2'b00) && lo_en);
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  tick_r, tick_s;
    logic [1:0]  op_r, op_s;
    logic [15:0] addr_r, addr_s;
    logic [7:0]  wdata_r, wdata_s;
    logic        cmd_ready_r, cmd_ready_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic [7:0]  rsp_rdata_r, rsp_rdata_s;
    logic        rsp_romdis_r, rsp_romdis_s;
    logic        mreq_b_r, mreq_b_s;
    logic        ioreq_b_r, ioreq_b_s;
    logic        rd_b_r, rd_b_s;
    logic        wr_b_r, wr_b_s;
    logic        romen_b_r, romen_b_s;
    logic        d_oe_r, d_oe_s;
    logic [7:0]  d_out_r, d_out_s;
    logic        accept_s, nop_accept_s, tick_last_s, active_s, wr_phase_s;

    // Sequencer: next state, tick count, command latch and response capture.
    always_comb begin
        accept_s     = bus.cmd_valid && cmd_ready_r;
        nop_accept_s = accept_s && (bus.cmd_op == OP_NOP);
        tick_last_s  = (tick_r == TICK_LAST);
        state_s      = state_r;
        op_s         = op_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        rsp_valid_s  = 1'b0;
        rsp_rdata_s  = rsp_rdata_r;
        rsp_romdis_s = rsp_romdis_r;
        case (state_r)
            ST_IDLE: begin
                if (nop_accept_s) begin
                    rsp_valid_s  = 1'b1;
                    rsp_rdata_s  = 8'h00;
                    rsp_romdis_s = bus.ROMDIS;
                end else if (accept_s) begin
                    state_s = ST_T1;
                    op_s    = bus.cmd_op;
                    addr_s  = bus.cmd_addr;
                    wdata_s = bus.cmd_wdata;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_T1: begin
                if (tick_last_s) begin
                    state_s = ST_T2;
                end else begin
                    state_s = ST_T1;
                end
            end
            ST_T2: begin
                // IO cycles always take one wait state; memory cycles only on READY low.
                if (tick_last_s && ((op_r == OP_IOWR) || !bus.READY)) begin
                    state_s = ST_TW;
                end else if (tick_last_s) begin
                    state_s = ST_T3;
                end else begin
                    state_s = ST_T2;
                end
            end
            ST_TW: begin
                if (tick_last_s && bus.READY) begin
                    state_s = ST_T3;
                end else begin
                    state_s = ST_TW;
                end
            end
            ST_T3: begin
                if (tick_last_s) begin
                    state_s      = ST_IDLE;
                    rsp_valid_s  = 1'b1;
                    rsp_rdata_s  = (op_r == OP_MRD) ? bus.D_IN : 8'h00;
                    rsp_romdis_s = bus.ROMDIS;
                end else begin
                    state_s = ST_T3;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Tick restarts on every state change and wraps when a TW repeats.
        if ((state_r == ST_IDLE) || (state_s != state_r) || tick_last_s) begin
            tick_s = 4'd0;
        end else begin
            tick_s = tick_r + 4'd1;
        end
    end

    // Strobe decode for the state being entered, so the registered pins line up with it.
    always_comb begin
        active_s   = (state_s != ST_IDLE);
        wr_phase_s = (state_s == ST_T2) || (state_s == ST_TW) || (state_s == ST_T3);
        mreq_b_s   = 1'b1;
        ioreq_b_s  = 1'b1;
        rd_b_s     = 1'b1;
        wr_b_s     = 1'b1;
        romen_b_s  = 1'b1;
        d_oe_s     = 1'b0;
        case (op_s)
            OP_MRD: begin
                mreq_b_s  = !active_s;
                rd_b_s    = !active_s;
                romen_b_s = !(active_s && romen_hit(addr_s, bus.upper_en, bus.lower_en));
            end
            OP_MWR: begin
                mreq_b_s = !active_s;
                wr_b_s   = !wr_phase_s;
                d_oe_s   = active_s;
            end
            OP_IOWR: begin
                ioreq_b_s = !wr_phase_s;
                wr_b_s    = !wr_phase_s;
                d_oe_s    = active_s;
            end
            default: begin
                d_oe_s = 1'b0;
            end
        endcase
        if (d_oe_s) begin
            d_out_s = wdata_s;
        end else begin
            d_out_s = 8'h00;
        end
        // No new command during a NOP response cycle, giving two-cycle spacing.
        cmd_ready_s = (state_s == ST_IDLE) && !nop_accept_s;
    end

    // State, latch and output registers; reset drops any in-flight command.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            tick_r       <= 4'd0;
            op_r         <= OP_NOP;
            addr_r       <= 16'h0000;
            wdata_r      <= 8'h00;
            cmd_ready_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 8'h00;
            rsp_romdis_r <= 1'b0;
            mreq_b_r     <= 1'b1;
            ioreq_b_r    <= 1'b1;
            rd_b_r       <= 1'b1;
            wr_b_r       <= 1'b1;
            romen_b_r    <= 1'b1;
            d_oe_r       <= 1'b0;
            d_out_r      <= 8'h00;
        end else begin
            state_r      <= state_s;
            tick_r       <= tick_s;
            op_r         <= op_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            cmd_ready_r  <= cmd_ready_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_rdata_r  <= rsp_rdata_s;
            rsp_romdis_r <= rsp_romdis_s;
            mreq_b_r     <= mreq_b_s;
            ioreq_b_r    <= ioreq_b_s;
            rd_b_r       <= rd_b_s;
            wr_b_r       <= wr_b_s;
            romen_b_r    <= romen_b_s;
            d_oe_r       <= d_oe_s;
            d_out_r      <= d_out_s;
        end
    end

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_rdata  = rsp_rdata_r;
    assign bus.rsp_romdis = rsp_romdis_r;
    assign bus.A          = addr_r;
    assign bus.D_OUT      = d_out_r;
    assign bus.D_OE       = d_oe_r;
    assign bus.MREQ_B     = mreq_b_r;
    assign bus.IOREQ_B    = ioreq_b_r;
    assign bus.RD_B       = rd_b_r;
    assign bus.WR_B       = wr_b_r;
    assign bus.ROMEN_B    = romen_b_r;
endmodule
